merge_align_unit: RTL and testbench

MERGE_ALIGN_UNIT -- requirements
Module: merge_align_unit

---
 rtl/merge_align_unit.sv | 151 +++++++++++++++
 tb/tb_merge_align_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/merge_align_unit.sv
// rtl/merge_align_unit.sv - misaligned load merge/extract unit with in-order result buffer
module merge_align_unit #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned TRANS_ID_BITS = 3,
  parameter int unsigned DEPTH         = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic [XLEN-1:0]              operand_lo_i,
  input  logic [XLEN-1:0]              operand_hi_i,
  input  logic [$clog2(XLEN/8)-1:0]    offset_i,
  input  logic [1:0]                   size_i,
  input  logic                         sign_ext_i,
  input  logic [TRANS_ID_BITS-1:0]     trans_id_i,
  output logic [XLEN-1:0]              result_o,
  output logic [TRANS_ID_BITS-1:0]     trans_id_o,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         illegal_o
);

  localparam int unsigned OFF_W = $clog2(XLEN/8);
  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  // Buffer bookkeeping
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  // Buffer storage
  logic [XLEN-1:0]          res_mem [DEPTH];
  logic [TRANS_ID_BITS-1:0] id_mem  [DEPTH];
  logic                     ill_mem [DEPTH];

  // Handshake qualifiers
  logic push;
  logic pop;
  logic head_valid;

  // Extraction datapath
  logic [2*XLEN-1:0] shifted;
  logic [6:0]        field_bits;
  logic              field_top;
  logic [XLEN-1:0]   keep_mask;
  logic [XLEN-1:0]   extracted;
  logic              size_illegal;

  // ready_o only looks at stored occupancy so it never depends on the consumer
  assign ready_o    = (count < CNT_W'(DEPTH));
  assign head_valid = (count != '0) && !flush_i;
  assign valid_o    = head_valid;

  // A flush cycle swallows both sides of the handshake
  assign push = valid_i && ready_o && !flush_i;
  assign pop  = head_valid && ready_i;

  // Align the requested byte to bit 0 of the concatenated double word
  always_comb begin
    shifted = {operand_hi_i, operand_lo_i} >> {offset_i, 3'b000};
  end

  // Select field width and the bit used for sign extension
  always_comb begin
    field_bits   = 7'd8;
    field_top    = shifted[7];
    size_illegal = 1'b0;
    case (size_i)
      2'b00: begin
        field_bits = 7'd8;
        field_top  = shifted[7];
      end
      2'b01: begin
        field_bits = 7'd16;
        field_top  = shifted[15];
      end
      2'b10: begin
        field_bits = 7'd32;
        field_top  = shifted[31];
      end
      default: begin
        field_bits   = 7'(XLEN);
        field_top    = shifted[XLEN-1];
        size_illegal = (XLEN == 32);
      end
    endcase
  end

  // Keep the field and fill the upper bits; a full-width field gets an all-ones
  // mask so nothing is extended
  always_comb begin
    keep_mask = ~({XLEN{1'b1}} << field_bits);
    if (size_illegal) begin
      extracted = '0;
    end else if (sign_ext_i && field_top) begin
      extracted = (shifted[XLEN-1:0] & keep_mask) | ~keep_mask;
    end else begin
      extracted = shifted[XLEN-1:0] & keep_mask;
    end
  end

  // Pointers and occupancy; flush wins over any same-cycle push/pop
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Result storage is only meaningful under count, so it needs no reset
  always_ff @(posedge clk_i) begin
    if (push) begin
      res_mem[wr_ptr] <= extracted;
      id_mem[wr_ptr]  <= trans_id_i;
      ill_mem[wr_ptr] <= size_illegal;
    end
  end

  // Present the head entry, forced to zero whenever nothing is valid
  always_comb begin
    result_o   = '0;
    trans_id_o = '0;
    illegal_o  = 1'b0;
    if (head_valid) begin
      result_o   = res_mem[rd_ptr];
      trans_id_o = id_mem[rd_ptr];
      illegal_o  = ill_mem[rd_ptr];
    end
  end

endmodule

// File: tb/tb_merge_align_unit.sv
// tb/tb_merge_align_unit.sv - self-checking bench for merge_align_unit
module tb_merge_align_unit;

  localparam int DEPTH = 2;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] operand_lo_i;
  logic [31:0] operand_hi_i;
  logic [1:0]  offset_i;
  logic [1:0]  size_i;
  logic        sign_ext_i;
  logic [2:0]  trans_id_i;
  logic [31:0] result_o;
  logic [2:0]  trans_id_o;
  logic        valid_o;
  logic        ready_i;
  logic        illegal_o;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] r;
    logic [2:0]  id;
    logic        ill;
  } ent_t;

  ent_t q[$];

  merge_align_unit #(.XLEN(32), .TRANS_ID_BITS(3), .DEPTH(DEPTH)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .valid_i(valid_i), .ready_o(ready_o),
    .operand_lo_i(operand_lo_i), .operand_hi_i(operand_hi_i),
    .offset_i(offset_i), .size_i(size_i), .sign_ext_i(sign_ext_i),
    .trans_id_i(trans_id_i), .result_o(result_o), .trans_id_o(trans_id_o),
    .valid_o(valid_o), .ready_i(ready_i), .illegal_o(illegal_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: pick bytes out of the little-endian memory image, then extend arithmetically
  function automatic ent_t ref_ent();
    logic [7:0]  b [8];
    logic [63:0] val;
    int          n;
    ent_t        e;
    for (int i = 0; i < 4; i++) begin
      b[i]   = operand_lo_i[8*i +: 8];
      b[4+i] = operand_hi_i[8*i +: 8];
    end
    e.id = trans_id_i;
    if (size_i == 2'b11) begin
      e.r   = 32'h0;
      e.ill = 1'b1;
      return e;
    end
    n   = 1 << size_i;
    val = 64'h0;
    for (int i = 0; i < n; i++) val = val + (64'(b[int'(offset_i) + i]) << (8 * i));
    if (sign_ext_i && b[int'(offset_i) + n - 1][7]) val = val - (64'h1 << (8 * n));
    e.r   = val[31:0];
    e.ill = 1'b0;
    return e;
  endfunction

  task automatic compare_model();
    logic ev;
    #1;
    ev = (q.size() > 0) && !flush_i;
    chk("valid_o", 32'(valid_o), 32'(ev));
    chk("ready_o", 32'(ready_o), 32'(q.size() < DEPTH));
    chk("result_o", result_o, ev ? q[0].r : 32'h0);
    chk("trans_id_o", 32'(trans_id_o), ev ? 32'(q[0].id) : 32'h0);
    chk("illegal_o", 32'(illegal_o), ev ? 32'(q[0].ill) : 32'h0);
  endtask

  task automatic model_edge();
    logic do_push, do_pop;
    ent_t e;
    do_push = valid_i && (q.size() < DEPTH) && !flush_i;
    do_pop  = (q.size() > 0) && ready_i && !flush_i;
    e = ref_ent();
    if (flush_i) q.delete();
    else begin
      if (do_pop) void'(q.pop_front());
      if (do_push) q.push_back(e);
    end
  endtask

  task automatic step();
    compare_model();
    model_edge();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic req(input logic [31:0] lo, input logic [31:0] hi, input logic [1:0] off,
                     input logic [1:0] sz, input logic sx, input logic [2:0] id);
    valid_i = 1'b1; operand_lo_i = lo; operand_hi_i = hi;
    offset_i = off; size_i = sz; sign_ext_i = sx; trans_id_i = id;
  endtask

  initial begin
    rst_ni = 1'b0; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    operand_lo_i = 32'h0; operand_hi_i = 32'h0; offset_i = 2'd0;
    size_i = 2'd0; sign_ext_i = 1'b0; trans_id_i = 3'd0;

    // reset state
    #1;
    chk("rst_valid", 32'(valid_o), 32'h0);
    chk("rst_ready", 32'(ready_o), 32'h1);
    chk("rst_result", result_o, 32'h0);
    chk("rst_id", 32'(trans_id_o), 32'h0);
    chk("rst_ill", 32'(illegal_o), 32'h0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // word extraction, latency one
    req(32'h44332211, 32'h88776655, 2'd1, 2'b10, 1'b0, 3'd5);
    step();
    valid_i = 1'b0;
    #1;
    chk("word_valid", 32'(valid_o), 32'h1);
    chk("word_result", result_o, 32'h55443322);
    chk("word_id", 32'(trans_id_o), 32'd5);
    ready_i = 1'b1;
    step();

    // half and byte with sign/zero extension
    req(32'h44332211, 32'h88776655, 2'd3, 2'b01, 1'b1, 3'd1);
    step(); valid_i = 1'b0; #1;
    chk("half_sx", result_o, 32'h00005544);
    step();
    req(32'h84332211, 32'h88776655, 2'd3, 2'b00, 1'b1, 3'd2);
    step(); valid_i = 1'b0; #1;
    chk("byte_sx", result_o, 32'hFFFFFF84);
    step();
    req(32'h84332211, 32'h88776655, 2'd3, 2'b00, 1'b0, 3'd3);
    step(); valid_i = 1'b0; #1;
    chk("byte_zx", result_o, 32'h00000084);
    step();

    // backpressure: third request refused while full
    ready_i = 1'b0;
    req(32'h1, 32'h2, 2'd0, 2'b10, 1'b0, 3'd1); step();
    req(32'h3, 32'h4, 2'd0, 2'b10, 1'b0, 3'd2); step();
    #1;
    chk("full_ready", 32'(ready_o), 32'h0);
    req(32'h5, 32'h6, 2'd0, 2'b10, 1'b0, 3'd3); step();
    valid_i = 1'b0; ready_i = 1'b1; #1;
    chk("full_head1", 32'(trans_id_o), 32'd1);
    step(); #1;
    chk("full_head2", 32'(trans_id_o), 32'd2);
    step(); #1;
    chk("drain_valid", 32'(valid_o), 32'h0);
    chk("drain_ready", 32'(ready_o), 32'h1);

    // simultaneous push and pop with one entry held
    ready_i = 1'b0;
    req(32'h11, 32'h0, 2'd0, 2'b00, 1'b0, 3'd4); step();
    ready_i = 1'b1;
    req(32'h22, 32'h0, 2'd0, 2'b00, 1'b0, 3'd6); step();
    valid_i = 1'b0; ready_i = 1'b0; #1;
    chk("pp_id", 32'(trans_id_o), 32'd6);
    chk("pp_ready", 32'(ready_o), 32'h1);
    ready_i = 1'b1; step();

    // flush with a concurrent request
    ready_i = 1'b0;
    req(32'hAA, 32'h0, 2'd0, 2'b00, 1'b0, 3'd1); step();
    req(32'hBB, 32'h0, 2'd0, 2'b00, 1'b0, 3'd2); step();
    flush_i = 1'b1;
    req(32'hCC, 32'h0, 2'd0, 2'b00, 1'b0, 3'd3); #1;
    chk("flush_valid_now", 32'(valid_o), 32'h0);
    step();
    flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b1; #1;
    chk("flush_valid", 32'(valid_o), 32'h0);
    chk("flush_ready", 32'(ready_o), 32'h1);
    step(); step();

    // illegal size then legal
    req(32'h12345678, 32'h9ABCDEF0, 2'd0, 2'b11, 1'b1, 3'd7); step();
    req(32'h12345678, 32'h9ABCDEF0, 2'd0, 2'b00, 1'b0, 3'd1); #1;
    chk("ill_flag", 32'(illegal_o), 32'h1);
    chk("ill_result", result_o, 32'h0);
    chk("ill_id", 32'(trans_id_o), 32'd7);
    step(); valid_i = 1'b0; #1;
    chk("legal_flag", 32'(illegal_o), 32'h0);
    chk("legal_result", result_o, 32'h78);
    step();

    // reset in mid-operation
    ready_i = 1'b0;
    req(32'h1, 32'h0, 2'd0, 2'b00, 1'b0, 3'd1); step();
    req(32'h2, 32'h0, 2'd0, 2'b00, 1'b0, 3'd2); step();
    valid_i = 1'b0; rst_ni = 1'b0; q.delete(); #1;
    chk("mrst_valid", 32'(valid_o), 32'h0);
    chk("mrst_ready", 32'(ready_o), 32'h1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    req(32'h5A, 32'h0, 2'd0, 2'b00, 1'b0, 3'd3); step();
    valid_i = 1'b0; #1;
    chk("mrst_first", 32'(trans_id_o), 32'd3);
    ready_i = 1'b1; step();

    // randomized traffic against the reference queue
    for (int i = 0; i < 400; i++) begin
      valid_i      = ($urandom_range(0, 3) != 0);
      ready_i      = ($urandom_range(0, 1) != 0);
      flush_i      = ($urandom_range(0, 15) == 0);
      operand_lo_i = $urandom;
      operand_hi_i = $urandom;
      offset_i     = 2'($urandom_range(0, 3));
      size_i       = 2'($urandom_range(0, 3));
      sign_ext_i   = ($urandom_range(0, 1) != 0);
      trans_id_i   = 3'($urandom_range(0, 7));
      step();
    end
    flush_i = 1'b0; valid_i = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
